// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: definitions shared by the instruction-memory loader.
//   MAGIC_DEFAULT  - default frame start byte
//   HDR_BYTES      - header length in bytes (MAGIC, LEN_HI, LEN_LO)
//   LEN_W          - width of the word-count field carried in the header
//   ST_*           - 3-bit FSM state encodings, state_e - the FSM state type
//   len_too_long() - true when a header word count exceeds the imem capacity

package imem_loader_pkg;

    localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;

    // MAGIC plus a big-endian length field; everything after MAGIC is length.
    localparam int unsigned HDR_BYTES = 3;
    localparam int unsigned LEN_W     = 8 * (HDR_BYTES - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LEN_HI = 3'd1;
    localparam logic [2:0] ST_LEN_LO = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_CSUM   = 3'd4;

    typedef enum logic [2:0] {
        StIdle  = ST_IDLE,
        StLenHi = ST_LEN_HI,
        StLenLo = ST_LEN_LO,
        StData  = ST_DATA,
        StCsum  = ST_CSUM
    } state_e;

    // A frame may fill the whole imem (2^aw words) but not one word more.
    // One extra bit keeps 2^aw representable when aw equals LEN_W.
    function automatic logic len_too_long(input logic [LEN_W-1:0] len, input int unsigned aw);
        logic [LEN_W:0] cap;
        cap = (LEN_W + 1)'(1) << aw;
        return ({1'b0, len} > cap);
    endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// imem_loader_word_assembler: packs the big-endian data bytes of a frame into
// 32-bit words and keeps the running XOR checksum of every data byte.
//   clock, reset   - master clock, asynchronous active-high reset
//   clear          - start of a new frame: empties the word and zeroes the checksum
//   byte_valid     - byte_data is a data byte to be consumed this cycle
//   byte_data      - data byte
//   word_next      - assembled word, meaningful while word_ready is high
//   word_ready     - combinational strobe: this byte completes a word
//   csum           - XOR of all data bytes consumed since the last clear

module imem_loader_word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] word_next,
    output logic        word_ready,
    output logic [7:0]  csum
);

    // Only the first three bytes of a word need storing; the fourth is taken
    // straight from byte_data so the word is ready in the cycle it arrives.
    logic [23:0] shift_q;
    logic [1:0]  cnt_q;
    logic [7:0]  csum_q;

    assign word_next  = {shift_q, byte_data};
    assign word_ready = byte_valid && (cnt_q == 2'd3);
    assign csum       = csum_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shift_q <= '0;
            cnt_q   <= '0;
            csum_q  <= '0;
        end else if (clear) begin
            shift_q <= '0;
            cnt_q   <= '0;
            csum_q  <= '0;
        end else if (byte_valid) begin
            shift_q <= {shift_q[15:0], byte_data};
            // Wraps 3 -> 0 so the next word starts without extra control.
            cnt_q   <= cnt_q + 2'd1;
            csum_q  <= csum_q ^ byte_data;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: parses a framed program image from the UART byte stream and
// writes it into the processor's instruction memory, holding the processor
// in reset while a frame is being loaded.
// Frame: MAGIC, LEN_HI, LEN_LO, LEN big-endian 32-bit words, CSUM (XOR of data).
//   clock, reset   - master clock, asynchronous active-high reset
//   rx_valid       - one-cycle strobe, rx_data valid (may be back-to-back)
//   rx_data        - received byte
//   imem_wren      - one-cycle write pulse per word
//   imem_addr      - word address of the write
//   imem_wdata     - word written
//   cpu_reset      - processor reset; held from frame start until a good CSUM
//   busy           - frame in progress
//   load_done      - sticky, last frame succeeded
//   load_error     - sticky, last frame failed (length, checksum or timeout)

module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 12,
    parameter logic [7:0]  MAGIC          = MAGIC_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  imem_wren,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_reset,
    output logic                  busy,
    output logic                  load_done,
    output logic                  load_error
);

    localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

    state_e                state_q;
    logic [7:0]            len_hi_q;
    logic [ADDR_WIDTH-1:0] word_idx_q;
    logic [ADDR_WIDTH-1:0] last_idx_q;
    logic [IDLE_W-1:0]     idle_cnt_q;

    logic [LEN_W-1:0]      len_full;
    logic                  frame_start;
    logic                  asm_valid;
    logic                  timeout;
    logic [31:0]           word_next;
    logic                  word_ready;
    logic [7:0]            csum;

    // Only meaningful in StLenLo, where rx_data is the low length byte.
    assign len_full    = {len_hi_q, rx_data};
    assign frame_start = (state_q == StIdle) && rx_valid && (rx_data == MAGIC);
    assign asm_valid   = (state_q == StData) && rx_valid;
    // A byte arriving on the last allowed cycle still counts as in time.
    assign timeout     = (state_q != StIdle) && !rx_valid && (idle_cnt_q == IDLE_LAST);

    imem_loader_word_assembler u_word_assembler (
        .clock      (clock),
        .reset      (reset),
        .clear      (frame_start),
        .byte_valid (asm_valid),
        .byte_data  (rx_data),
        .word_next  (word_next),
        .word_ready (word_ready),
        .csum       (csum)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            len_hi_q   <= '0;
            word_idx_q <= '0;
            last_idx_q <= '0;
            idle_cnt_q <= '0;
            imem_wren  <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_reset  <= 1'b0;
            busy       <= 1'b0;
            load_done  <= 1'b0;
            load_error <= 1'b0;
        end else begin
            imem_wren <= 1'b0;

            if (rx_valid || (state_q == StIdle)) begin
                idle_cnt_q <= '0;
            end else begin
                idle_cnt_q <= idle_cnt_q + IDLE_W'(1);
            end

            if (timeout) begin
                // cpu_reset stays asserted: the image in imem is incomplete.
                load_error <= 1'b1;
                busy       <= 1'b0;
                state_q    <= StIdle;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (frame_start) begin
                            cpu_reset  <= 1'b1;
                            busy       <= 1'b1;
                            load_done  <= 1'b0;
                            load_error <= 1'b0;
                            word_idx_q <= '0;
                            state_q    <= StLenHi;
                        end
                    end

                    StLenHi: begin
                        if (rx_valid) begin
                            len_hi_q <= rx_data;
                            state_q  <= StLenLo;
                        end
                    end

                    StLenLo: begin
                        if (rx_valid) begin
                            // Don't-care when the length is zero or rejected.
                            last_idx_q <= ADDR_WIDTH'(len_full - LEN_W'(1));
                            if (len_too_long(len_full, ADDR_WIDTH)) begin
                                load_error <= 1'b1;
                                busy       <= 1'b0;
                                state_q    <= StIdle;
                            end else if (len_full == '0) begin
                                state_q <= StCsum;
                            end else begin
                                state_q <= StData;
                            end
                        end
                    end

                    StData: begin
                        if (word_ready) begin
                            imem_wren  <= 1'b1;
                            imem_wdata <= word_next;
                            imem_addr  <= word_idx_q;
                            word_idx_q <= word_idx_q + ADDR_WIDTH'(1);
                            if (word_idx_q == last_idx_q) begin
                                state_q <= StCsum;
                            end
                        end
                    end

                    StCsum: begin
                        if (rx_valid) begin
                            busy    <= 1'b0;
                            state_q <= StIdle;
                            if (rx_data == csum) begin
                                load_done <= 1'b1;
                                cpu_reset <= 1'b0;
                            end else begin
                                load_error <= 1'b1;
                            end
                        end
                    end

                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    localparam int AW = 12;
    localparam int TO = 50;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          imem_wren;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_reset;
    logic          busy;
    logic          load_done;
    logic          load_error;

    imem_loader #(
        .ADDR_WIDTH     (AW),
        .MAGIC          (8'hA5),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .imem_wren  (imem_wren),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .busy       (busy),
        .load_done  (load_done),
        .load_error (load_error)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    logic [7:0]    frame_q[$];
    logic [AW-1:0] wr_addr_q[$];
    logic [31:0]   wr_data_q[$];

    // Every cycle with wren high is a write; a stretched pulse shows up as an extra write.
    always @(negedge clock) begin
        if (imem_wren) begin
            wr_addr_q.push_back(imem_addr);
            wr_data_q.push_back(imem_wdata);
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clock);
        #1;
        rx_valid = 1'b0;
        if (gap > 0) cycles(gap);
    endtask

    // Sends frame_q; no gap after the last byte so the caller sees the state right after it.
    task automatic send_frame(input int gap, input bit random_gap);
        int g;
        for (int i = 0; i < frame_q.size(); i++) begin
            g = random_gap ? int'($urandom_range(0, 2)) : gap;
            send_byte(frame_q[i], (i == frame_q.size() - 1) ? 0 : g);
        end
    endtask

    task automatic send_garbage(input int n);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            if (b == 8'hA5) b = 8'h00;
            send_byte(b, 1);
        end
    endtask

    function automatic logic [7:0] data_xor(input int len);
        logic [7:0] x = 8'h00;
        for (int i = 0; i < 4 * len; i++) x ^= frame_q[3 + i];
        return x;
    endfunction

    task automatic build_frame(input int len, input bit bad);
        logic [7:0] cs;
        frame_q.delete();
        frame_q.push_back(8'hA5);
        frame_q.push_back(8'(len >> 8));
        frame_q.push_back(8'(len));
        for (int i = 0; i < 4 * len; i++) frame_q.push_back(8'($urandom));
        cs = data_xor(len);
        if (bad) cs ^= 8'($urandom_range(1, 255));
        frame_q.push_back(cs);
    endtask

    task automatic clear_writes();
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    // Reference: decode the frame bytes directly and compare the observed outcome.
    task automatic check_frame(input string name);
        int len, nw, n;
        bit ok;
        logic [31:0] w;
        len = (int'(frame_q[1]) << 8) | int'(frame_q[2]);
        if (len > (1 << AW)) begin
            ok = 1'b0;
            nw = 0;
        end else begin
            nw = len;
            ok = (frame_q[3 + 4 * len] == data_xor(len));
        end
        checks++;
        if (wr_addr_q.size() != nw) begin
            failures++;
            $display("FAIL %s write_count: got %0d expected %0d", name, wr_addr_q.size(), nw);
        end
        n = (wr_addr_q.size() < nw) ? wr_addr_q.size() : nw;
        for (int i = 0; i < n; i++) begin
            w = {frame_q[3 + 4 * i], frame_q[4 + 4 * i], frame_q[5 + 4 * i], frame_q[6 + 4 * i]};
            checks++;
            if (wr_addr_q[i] !== AW'(i) || wr_data_q[i] !== w) begin
                failures++;
                $display("FAIL %s write[%0d]: got %h@%h expected %h@%h", name, i,
                         wr_data_q[i], wr_addr_q[i], w, AW'(i));
            end
        end
        checks++;
        if (load_done !== ok || load_error !== !ok || cpu_reset !== !ok || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s status: got done=%b err=%b cpu_reset=%b busy=%b expected %b %b %b 0",
                     name, load_done, load_error, cpu_reset, busy, ok, !ok, !ok);
        end
    endtask

    task automatic check_outputs_reset(input string name);
        checks++;
        if (imem_wren !== 1'b0 || imem_addr !== '0 || imem_wdata !== 32'h0 || cpu_reset !== 1'b0
            || busy !== 1'b0 || load_done !== 1'b0 || load_error !== 1'b0) begin
            failures++;
            $display("FAIL %s: got wren=%b addr=%h wdata=%h cpu_reset=%b busy=%b done=%b err=%b expected all zero",
                     name, imem_wren, imem_addr, imem_wdata, cpu_reset, busy, load_done, load_error);
        end
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        #1 check_outputs_reset("reset_values");
        cycles(3);
        reset = 1'b0;
        cycles(2);
        check_outputs_reset("after_reset_release");
    endtask

    task automatic test_gapped_frame();
        logic [7:0] bytes_a[11] = '{8'hA5, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44,
                                    8'hAA, 8'hBB, 8'hCC, 8'hDD};
        clear_writes();
        frame_q.delete();
        foreach (bytes_a[i]) frame_q.push_back(bytes_a[i]);
        frame_q.push_back(data_xor(2));
        send_byte(frame_q[0], 1);
        checks++;
        if (busy !== 1'b1 || cpu_reset !== 1'b1 || load_done !== 1'b0) begin
            failures++;
            $display("FAIL gapped_start: got busy=%b cpu_reset=%b done=%b expected 1 1 0",
                     busy, cpu_reset, load_done);
        end
        for (int i = 1; i < frame_q.size() - 1; i++) send_byte(frame_q[i], 1);
        checks++;
        if (cpu_reset !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL gapped_pre_csum: got cpu_reset=%b busy=%b expected 1 1", cpu_reset, busy);
        end
        send_byte(frame_q[frame_q.size() - 1], 0);
        check_frame("gapped_frame");
        cycles(2);
    endtask

    task automatic test_back_to_back();
        clear_writes();
        frame_q = '{8'hA5, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        frame_q.push_back(data_xor(2));
        send_frame(0, 1'b0);
        check_frame("back_to_back");
        cycles(2);
    endtask

    task automatic test_bad_csum();
        clear_writes();
        frame_q = '{8'hA5, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC,
                    8'hDD, 8'hFF};
        send_frame(1, 1'b0);
        check_frame("bad_csum");
        cycles(3);
        clear_writes();
        build_frame(3, 1'b0);
        send_frame(0, 1'b0);
        check_frame("recover_after_bad");
        cycles(2);
    endtask

    task automatic test_length_bounds();
        clear_writes();
        frame_q = '{8'hA5, 8'h00, 8'h00, 8'h00};
        send_frame(1, 1'b0);
        check_frame("zero_length");
        cycles(2);
        clear_writes();
        frame_q = '{8'hA5, 8'h10, 8'h01};
        send_frame(0, 1'b0);
        check_frame("length_too_long");
        cycles(5);
        checks++;
        if (wr_addr_q.size() != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL length_too_long_quiet: got writes=%0d busy=%b expected 0 0",
                     wr_addr_q.size(), busy);
        end
        clear_writes();
        build_frame(1 << AW, 1'b0);
        send_frame(0, 1'b0);
        check_frame("full_imem");
        cycles(2);
    endtask

    task automatic test_timeout();
        clear_writes();
        frame_q = '{8'h00, 8'hFF};
        send_frame(1, 1'b0);
        cycles(2);
        checks++;
        if (busy !== 1'b0 || load_error !== 1'b0 || load_done !== 1'b1) begin
            failures++;
            $display("FAIL garbage_ignored: got busy=%b err=%b done=%b expected 0 0 1",
                     busy, load_error, load_done);
        end
        frame_q = '{8'hA5, 8'h00, 8'h01, 8'h11, 8'h22};
        send_frame(0, 1'b0);
        cycles(TO - 1);
        checks++;
        if (load_error !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL timeout_early: got err=%b busy=%b expected 0 1", load_error, busy);
        end
        cycles(1);
        checks++;
        if (load_error !== 1'b1 || busy !== 1'b0 || cpu_reset !== 1'b1 || load_done !== 1'b0
            || wr_addr_q.size() != 0) begin
            failures++;
            $display("FAIL timeout: got err=%b busy=%b cpu_reset=%b done=%b writes=%0d expected 1 0 1 0 0",
                     load_error, busy, cpu_reset, load_done, wr_addr_q.size());
        end
        cycles(2);
    endtask

    task automatic test_reset_mid_frame();
        build_frame(3, 1'b0);
        for (int i = 0; i < 9; i++) send_byte(frame_q[i], 0);
        reset = 1'b1;
        #1 check_outputs_reset("reset_mid_frame");
        cycles(2);
        reset = 1'b0;
        cycles(2);
        check_outputs_reset("reset_mid_frame_idle");
    endtask

    task automatic test_random_frames();
        for (int t = 0; t < 10; t++) begin
            clear_writes();
            send_garbage(int'($urandom_range(0, 3)));
            build_frame(int'($urandom_range(0, 6)), ($urandom_range(0, 3) == 0));
            send_frame(0, 1'b1);
            check_frame($sformatf("random_%0d", t));
            cycles(2);
        end
    endtask

    initial begin
        test_reset();
        test_gapped_frame();
        test_back_to_back();
        test_bad_csum();
        test_length_bounds();
        test_timeout();
        test_reset_mid_frame();
        test_random_frames();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
